// File: rtl/csr_trap_ctrl_if.sv
// CSR access port between the trap controller (initiator) and the CSR file.
//   csr_raddr  : read address, driven by the initiator
//   csr_rdata  : combinational read data, returned by the CSR file in the same cycle
//   csr_w_addr : write address
//   csr_w_data : write data
//   csr_w_ena  : write enable; the CSR file commits on the next clk edge
interface csr_trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic [11:0]     csr_w_addr;
  logic [XLEN-1:0] csr_w_data;
  logic            csr_w_ena;

  modport master (
    output csr_raddr,
    input  csr_rdata,
    output csr_w_addr,
    output csr_w_data,
    output csr_w_ena
  );

  modport slave (
    input  csr_raddr,
    output csr_rdata,
    input  csr_w_addr,
    input  csr_w_data,
    input  csr_w_ena
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap / mret sequencer.
// On ecall, ebreak or an enabled external interrupt it writes mepc, mcause and
// mstatus one per cycle through the single CSR write port, then redirects the
// PC to mtvec. On mret it rewrites mstatus and redirects the PC to mepc.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ecall_i/ebreak_i/mret_i  instruction retiring in ex this cycle
//   int_req_i          external interrupt request (level)
//   inst_addr_i        PC of the instruction in ex
//   snoop_w_*_i        ex CSR write port, watched to track mstatus.MIE / mie.MEIE
//   csr                CSR read/write port (master side)
//   hold_o             stall the pipeline and hand the CSR ports to this block
//   jump_o/jump_addr_o one-cycle PC redirect and its target
module csr_trap_ctrl #(
  parameter int XLEN         = 64,
  parameter int ECALL_CAUSE  = 11,
  parameter int EBREAK_CAUSE = 3,
  parameter int INT_CAUSE    = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            int_req_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            snoop_w_ena_i,
  input  logic [11:0]     snoop_w_addr_i,
  input  logic [XLEN-1:0] snoop_w_data_i,
  csr_trap_ctrl_if.master csr,
  output logic            hold_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(ECALL_CAUSE);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(EBREAK_CAUSE);
  localparam logic [XLEN-1:0] CAUSE_INT    = {1'b1, (XLEN-1)'(INT_CAUSE)};
  localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_MEPC,
    S_T_MCAUSE,
    S_T_MSTATUS,
    S_T_JUMP,
    S_R_MSTATUS,
    S_R_JUMP
  } state_t;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] nxt;
    nxt         = cur;
    nxt[7]      = cur[3];
    nxt[3]      = 1'b0;
    nxt[12:11]  = 2'b11;
    return nxt;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP stays M (M-mode only core).
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] cur);
    logic [XLEN-1:0] nxt;
    nxt         = cur;
    nxt[3]      = cur[7];
    nxt[7]      = 1'b1;
    nxt[12:11]  = 2'b11;
    return nxt;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic            r_mstatus_mie;
  logic            r_mie_meie;

  logic            w_int_ok;
  logic            w_accept;
  logic [XLEN-1:0] w_cause;
  logic            w_hold;
  logic [11:0]     w_raddr;
  logic [11:0]     w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_wena;
  logic            w_jump;
  logic [XLEN-1:0] w_jaddr;
  logic            w_unused_snoop;

  assign w_int_ok       = int_req_i & r_mstatus_mie & r_mie_meie;
  assign w_unused_snoop = ^{snoop_w_data_i[XLEN-1:12], snoop_w_data_i[10:4],
                            snoop_w_data_i[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_cause       <= '0;
      r_mstatus_mie <= 1'b0;
      r_mie_meie    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_pc    <= inst_addr_i;
        r_cause <= w_cause;
      end
      // Own mstatus writes and snooped ones never coincide (pipeline is held).
      if (w_wena && (w_waddr == CSR_MSTATUS)) begin
        r_mstatus_mie <= w_wdata[3];
      end else if (snoop_w_ena_i && (snoop_w_addr_i == CSR_MSTATUS)) begin
        r_mstatus_mie <= snoop_w_data_i[3];
      end
      if (snoop_w_ena_i && (snoop_w_addr_i == CSR_MIE)) begin
        r_mie_meie <= snoop_w_data_i[11];
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cause  = '0;
    w_raddr  = '0;
    w_waddr  = '0;
    w_wdata  = '0;
    w_wena   = 1'b0;
    w_jump   = 1'b0;
    w_jaddr  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (ecall_i) begin
          w_accept = 1'b1;
          w_cause  = CAUSE_ECALL;
          w_next   = S_T_MEPC;
        end else if (ebreak_i) begin
          w_accept = 1'b1;
          w_cause  = CAUSE_EBREAK;
          w_next   = S_T_MEPC;
        end else if (mret_i) begin
          w_accept = 1'b1;
          w_next   = S_R_MSTATUS;
        end else if (w_int_ok) begin
          w_accept = 1'b1;
          w_cause  = CAUSE_INT;
          w_next   = S_T_MEPC;
        end
      end
      S_T_MEPC: begin
        w_wena  = 1'b1;
        w_waddr = CSR_MEPC;
        w_wdata = r_pc & ALIGN_MASK;
        w_next  = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        w_wena  = 1'b1;
        w_waddr = CSR_MCAUSE;
        w_wdata = r_cause;
        w_next  = S_T_MSTATUS;
      end
      S_T_MSTATUS: begin
        w_raddr = CSR_MSTATUS;
        w_wena  = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = trap_mstatus(csr.csr_rdata);
        w_next  = S_T_JUMP;
      end
      S_T_JUMP: begin
        // Direct mode only: mtvec mode bits are dropped.
        w_raddr = CSR_MTVEC;
        w_jump  = 1'b1;
        w_jaddr = csr.csr_rdata & ALIGN_MASK;
        w_next  = S_IDLE;
      end
      S_R_MSTATUS: begin
        w_raddr = CSR_MSTATUS;
        w_wena  = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = mret_mstatus(csr.csr_rdata);
        w_next  = S_R_JUMP;
      end
      S_R_JUMP: begin
        w_raddr = CSR_MEPC;
        w_jump  = 1'b1;
        w_jaddr = csr.csr_rdata;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset is sampled at the edge, but outputs are squashed in the reset
    // cycle itself so an in-flight write cannot commit.
    if (rst) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
      w_raddr  = '0;
      w_waddr  = '0;
      w_wdata  = '0;
      w_wena   = 1'b0;
      w_jump   = 1'b0;
      w_jaddr  = '0;
    end
    w_hold = ~rst & ((r_state != S_IDLE) | w_accept);
  end

  assign csr.csr_raddr  = w_raddr;
  assign csr.csr_w_addr = w_waddr;
  assign csr.csr_w_data = w_wdata;
  assign csr.csr_w_ena  = w_wena;
  assign hold_o         = w_hold;
  assign jump_o         = w_jump;
  assign jump_addr_o    = w_jaddr;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a small CSR file answers the DUT's CSR port and
// takes snooped writes; a reference model predicts the per-cycle outputs.
module tb_csr_trap_ctrl;
  localparam int XLEN = 64;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam int K_NONE = 0, K_ECALL = 1, K_EBREAK = 2, K_MRET = 3, K_INT = 4;

  typedef logic [142:0] obs_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            ecall_i, ebreak_i, mret_i, int_req_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            snoop_w_ena_i;
  logic [11:0]     snoop_w_addr_i;
  logic [XLEN-1:0] snoop_w_data_i;
  logic            hold_o, jump_o;
  logic [XLEN-1:0] jump_addr_o;

  csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  csr_trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11), .EBREAK_CAUSE(3), .INT_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i), .int_req_i(int_req_i),
    .inst_addr_i(inst_addr_i),
    .snoop_w_ena_i(snoop_w_ena_i), .snoop_w_addr_i(snoop_w_addr_i), .snoop_w_data_i(snoop_w_data_i),
    .csr(bus),
    .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  // CSR file seen by the DUT
  logic [XLEN-1:0] f_mstatus, f_mtvec, f_mepc, f_mcause, f_mie;

  always_comb begin
    case (bus.csr_raddr)
      A_MSTATUS: bus.csr_rdata = f_mstatus;
      A_MIE:     bus.csr_rdata = f_mie;
      A_MTVEC:   bus.csr_rdata = f_mtvec;
      A_MEPC:    bus.csr_rdata = f_mepc;
      A_MCAUSE:  bus.csr_rdata = f_mcause;
      default:   bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_w_ena) begin
      case (bus.csr_w_addr)
        A_MSTATUS: f_mstatus <= bus.csr_w_data;
        A_MIE:     f_mie     <= bus.csr_w_data;
        A_MTVEC:   f_mtvec   <= bus.csr_w_data;
        A_MEPC:    f_mepc    <= bus.csr_w_data;
        A_MCAUSE:  f_mcause  <= bus.csr_w_data;
        default: ;
      endcase
    end else if (snoop_w_ena_i) begin
      case (snoop_w_addr_i)
        A_MSTATUS: f_mstatus <= snoop_w_data_i;
        A_MIE:     f_mie     <= snoop_w_data_i;
        A_MTVEC:   f_mtvec   <= snoop_w_data_i;
        A_MEPC:    f_mepc    <= snoop_w_data_i;
        A_MCAUSE:  f_mcause  <= snoop_w_data_i;
        default: ;
      endcase
    end
  end

  // Reference model state
  logic [XLEN-1:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic            m_sh_ms, m_sh_me;
  obs_t            got   [0:11];
  obs_t            exp_o [0:11];
  int              total = 0;
  int              bad   = 0;

  function automatic obs_t mk(input logic h, input logic we, input logic [11:0] wa,
                              input logic [XLEN-1:0] wd, input logic j, input logic [XLEN-1:0] ja);
    return {h, we, wa, wd, j, ja};
  endfunction

  function automatic int pick_kind(input logic e, input logic b, input logic m, input logic i);
    if (e) return K_ECALL;
    if (b) return K_EBREAK;
    if (m) return K_MRET;
    if (i && m_sh_ms && m_sh_me) return K_INT;
    return K_NONE;
  endfunction

  // Expected outputs from the accept cycle (base) onward; updates model CSRs.
  task automatic model_seq(input int kind, input logic [XLEN-1:0] pc, input int base);
    logic [XLEN-1:0] cause, nm;
    if (kind == K_ECALL || kind == K_EBREAK || kind == K_INT) begin
      cause = (kind == K_ECALL) ? 64'd11 : (kind == K_EBREAK) ? 64'd3 : 64'h8000_0000_0000_000B;
      nm = (m_mstatus & ~64'h1888) | (m_mstatus[3] ? 64'h80 : 64'h0) | 64'h1800;
      exp_o[base]   = mk(1'b1, 1'b0, 12'h0, '0, 1'b0, '0);
      exp_o[base+1] = mk(1'b1, 1'b1, A_MEPC, pc & ~64'h3, 1'b0, '0);
      exp_o[base+2] = mk(1'b1, 1'b1, A_MCAUSE, cause, 1'b0, '0);
      exp_o[base+3] = mk(1'b1, 1'b1, A_MSTATUS, nm, 1'b0, '0);
      exp_o[base+4] = mk(1'b1, 1'b0, 12'h0, '0, 1'b1, m_mtvec & ~64'h3);
      m_mepc = pc & ~64'h3;
      m_mcause = cause;
      m_mstatus = nm;
      m_sh_ms = 1'b0;
    end else if (kind == K_MRET) begin
      nm = (m_mstatus & ~64'h1888) | (m_mstatus[7] ? 64'h8 : 64'h0) | 64'h1880;
      exp_o[base]   = mk(1'b1, 1'b0, 12'h0, '0, 1'b0, '0);
      exp_o[base+1] = mk(1'b1, 1'b1, A_MSTATUS, nm, 1'b0, '0);
      exp_o[base+2] = mk(1'b1, 1'b0, 12'h0, '0, 1'b1, m_mepc);
      m_mstatus = nm;
      m_sh_ms = nm[3];
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 12; k++) begin
      exp_o[k] = '0;
      got[k]   = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(output obs_t o);
    @(negedge clk);
    o = {hold_o, bus.csr_w_ena, bus.csr_w_addr, bus.csr_w_data, jump_o, jump_addr_o};
    @(posedge clk);
    #1;
  endtask

  task automatic snoop_wr(input logic [11:0] a, input logic [XLEN-1:0] d);
    snoop_w_ena_i = 1'b1;
    snoop_w_addr_i = a;
    snoop_w_data_i = d;
    tick();
    snoop_w_ena_i = 1'b0;
    case (a)
      A_MSTATUS: begin m_mstatus = d; m_sh_ms = d[3]; end
      A_MIE:     m_sh_me = d[11];
      A_MTVEC:   m_mtvec = d;
      A_MEPC:    m_mepc = d;
      A_MCAUSE:  m_mcause = d;
      default: ;
    endcase
  endtask

  // Request held for the accept cycle only, then n cycles observed.
  task automatic run_req(input logic e, input logic b, input logic m, input logic i,
                         input logic [XLEN-1:0] pc, input int n);
    ecall_i = e; ebreak_i = b; mret_i = m; int_req_i = i; inst_addr_i = pc;
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; int_req_i = 1'b0;
      end
      sample(got[k]);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    sample(o);
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_in_rst got=%h exp=0", o); end
    rst = 1'b0;
    sample(o);
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_idle got=%h exp=0", o); end
    snoop_wr(A_MCAUSE, 64'h55);
    snoop_wr(A_MTVEC, 64'h100);
    snoop_wr(A_MSTATUS, 64'h0);
    clear_exp();
    exp_o[0] = mk(1'b1, 1'b0, 12'h0, '0, 1'b0, '0);
    exp_o[1] = mk(1'b1, 1'b1, A_MEPC, 64'h1234, 1'b0, '0);
    ecall_i = 1'b1; inst_addr_i = 64'h1234;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) ecall_i = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      sample(got[k]);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
    total++;
    if (f_mcause !== 64'h55) begin bad++; $display("FAIL reset_mcause got=%h exp=55", f_mcause); end
    total++;
    if (f_mepc !== 64'h1234) begin bad++; $display("FAIL reset_mepc got=%h exp=1234", f_mepc); end
    m_mepc = 64'h1234; m_sh_ms = 1'b0; m_sh_me = 1'b0;
  endtask

  task automatic test_ecall();
    snoop_wr(A_MTVEC, 64'h8000_0100);
    snoop_wr(A_MSTATUS, 64'h8);
    clear_exp();
    model_seq(K_ECALL, 64'h8000_0010, 0);
    run_req(1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0010, 6);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL ecall cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
    total++;
    if ({f_mepc, f_mcause, f_mstatus} !== {64'h8000_0010, 64'd11, 64'h1880}) begin
      bad++; $display("FAIL ecall_csrs got=%h %h %h exp=80000010 b 1880", f_mepc, f_mcause, f_mstatus);
    end
  endtask

  task automatic test_mret();
    snoop_wr(A_MEPC, 64'h8000_0014);
    snoop_wr(A_MSTATUS, 64'h1880);
    clear_exp();
    model_seq(K_MRET, 64'h0, 0);
    run_req(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL mret cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
    total++;
    if (f_mstatus !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h exp=1888", f_mstatus); end
  endtask

  task automatic test_interrupt();
    snoop_wr(A_MIE, 64'h800);
    snoop_wr(A_MSTATUS, 64'h8);
    clear_exp();
    model_seq(K_INT, 64'h8000_0020, 0);
    run_req(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0020, 6);
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL int_en cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
    total++;
    if (f_mcause !== 64'h8000_0000_0000_000B) begin
      bad++; $display("FAIL int_mcause got=%h exp=800000000000000b", f_mcause);
    end
    snoop_wr(A_MSTATUS, 64'h0);
    clear_exp();
    run_req(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0030, 4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL int_masked cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    snoop_wr(A_MIE, 64'h800);
    snoop_wr(A_MSTATUS, 64'h8);
    snoop_wr(A_MTVEC, 64'h8000_0200);
    clear_exp();
    model_seq(K_ECALL, 64'h8000_0040, 0);
    m_mstatus = 64'h8; m_sh_ms = 1'b1;   // re-enabled by the snoop in the jump cycle
    model_seq(K_INT, 64'h8000_0044, 5);
    ecall_i = 1'b1; int_req_i = 1'b1; inst_addr_i = 64'h8000_0040;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) ecall_i = 1'b0;
      if (k == 4) begin
        snoop_w_ena_i = 1'b1; snoop_w_addr_i = A_MSTATUS; snoop_w_data_i = 64'h8;
      end
      if (k == 5) begin snoop_w_ena_i = 1'b0; inst_addr_i = 64'h8000_0044; end
      if (k == 6) int_req_i = 1'b0;
      sample(got[k]);
    end
    for (int k = 0; k < 11; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL b2b cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_int_pulse();
    snoop_wr(A_MIE, 64'h800);
    snoop_wr(A_MSTATUS, 64'h8);
    clear_exp();
    model_seq(K_ECALL, 64'h8000_0050, 0);
    ecall_i = 1'b1; inst_addr_i = 64'h8000_0050;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) ecall_i = 1'b0;
      if (k == 3) int_req_i = 1'b1;
      if (k == 4) begin
        int_req_i = 1'b0;
        snoop_w_ena_i = 1'b1; snoop_w_addr_i = A_MSTATUS; snoop_w_data_i = 64'h8;
      end
      if (k == 5) snoop_w_ena_i = 1'b0;
      sample(got[k]);
    end
    m_mstatus = 64'h8; m_sh_ms = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got[k] !== exp_o[k]) begin
        bad++; $display("FAIL int_pulse cyc%0d got=%h exp=%h", k, got[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_random();
    logic e, b, m, i;
    logic [XLEN-1:0] pc;
    int kind;
    for (int it = 0; it < 20; it++) begin
      snoop_wr(A_MIE, {$urandom, $urandom});
      snoop_wr(A_MSTATUS, {$urandom, $urandom});
      snoop_wr(A_MTVEC, {$urandom, $urandom});
      snoop_wr(A_MEPC, {$urandom, $urandom});
      e = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 1) == 0);
      pc = {$urandom, $urandom};
      kind = pick_kind(e, b, m, i);
      clear_exp();
      model_seq(kind, pc, 0);
      run_req(e, b, m, i, pc, 6);
      for (int k = 0; k < 6; k++) begin
        total++;
        if (got[k] !== exp_o[k]) begin
          bad++; $display("FAIL rand it%0d cyc%0d got=%h exp=%h", it, k, got[k], exp_o[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; int_req_i = 1'b0;
    inst_addr_i = '0;
    snoop_w_ena_i = 1'b0; snoop_w_addr_i = '0; snoop_w_data_i = '0;
    m_mstatus = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
    m_sh_ms = 1'b0; m_sh_me = 1'b0;
    tick();
    tick();
    test_reset();
    test_ecall();
    test_mret();
    test_interrupt();
    test_back_to_back();
    test_int_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
